// File: rtl/div_seq_32.sv
// Iterative non-restoring divider: one add/sub step per clock on a WIDTH+1 bit
// partial remainder, followed by a restore/sign-fix step and a one-cycle done.
// Optional signed division is compiled in when the macro DIV_SIGNED_EN is
// defined; otherwise is_signed is ignored and every op is unsigned.
module div_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             prep_q, prep_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             zero_q, zero_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             ovf_op_q, ovf_op_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             overflow_q, overflow_d;

  logic             signed_op;
  logic             x_neg, y_neg;
  logic [WIDTH-1:0] abs_x, abs_y;
  logic             min_by_neg1;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   step;
  logic [WIDTH-1:0] rem_mag;

`ifdef DIV_SIGNED_EN
  assign signed_op = is_signed;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign signed_op = 1'b0;
`endif

  // Operand conditioning at accept: magnitudes, result signs and the MIN/-1 case
  always_comb begin
    x_neg       = signed_op & dividend[WIDTH-1];
    y_neg       = signed_op & divisor[WIDTH-1];
    abs_x       = x_neg ? -dividend : dividend;
    abs_y       = y_neg ? -divisor : divisor;
    min_by_neg1 = signed_op & (dividend == MIN_VAL) & (divisor == {WIDTH{1'b1}});
  end

  // One non-restoring step; arithmetic wraps in WIDTH+1 bits but the true
  // partial remainder always lies in [-d, d) so it fits without loss
  always_comb begin
    shifted = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
    step    = rem_q[WIDTH] ? shifted + {1'b0, dvs_q} : shifted - {1'b0, dvs_q};
    rem_mag = rem_q[WIDTH] ? rem_q[WIDTH-1:0] + dvs_q : rem_q[WIDTH-1:0];
  end

  // Next-state and datapath control; the first RUN cycle screens the divisor
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    prep_d      = prep_q;
    rem_d       = rem_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    zero_d      = zero_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    ovf_op_d    = ovf_op_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          zero_d   = (divisor == '0);
          rem_d    = '0;
          q_d      = (divisor == '0) ? dividend : abs_x;
          dvs_d    = abs_y;
          q_neg_d  = x_neg ^ y_neg;
          r_neg_d  = x_neg;
          ovf_op_d = min_by_neg1;
          count_d  = '0;
          prep_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (prep_q) begin
          prep_d = 1'b0;
          if (zero_q) begin
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = q_q;
            div_zero_d  = 1'b1;
            overflow_d  = 1'b0;
            state_d     = DONE;
          end
        end else begin
          rem_d   = step;
          q_d     = {q_q[WIDTH-2:0], ~step[WIDTH]};
          count_d = count_q + 1'b1;
          if (count_q == LAST_COUNT) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        quotient_d  = q_neg_q ? -q_q : q_q;
        remainder_d = r_neg_q ? -rem_mag : rem_mag;
        div_zero_d  = 1'b0;
        overflow_d  = ovf_op_q;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      prep_q      <= 1'b0;
      rem_q       <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      zero_q      <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      ovf_op_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      prep_q      <= prep_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      zero_q      <= zero_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      ovf_op_q    <= ovf_op_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q == RUN) || (state_q == FIX);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_div_seq_32.sv
// Scoreboard bench for div_seq_32: stimulus pushes model results with their
// expected done cycle; a monitor checks done/busy timing, results and hold.
module tb_div_seq_32;

  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    longint       done_cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic         overflow;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  longint last_done_cyc = -10;
  exp_t   exp_q[$];
  logic [W-1:0] hold_q = '0;
  logic [W-1:0] hold_r = '0;
  logic         hold_dz = 1'b0;
  logic         hold_ov = 1'b0;

  div_seq_32 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic on the operands
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
    exp_t e;
    logic signed [W-1:0] sx;
    logic signed [W-1:0] sy;
    sx = x;
    sy = y;
    e.dz = 1'b0;
    e.ov = 1'b0;
    e.done_cyc = 0;
    if (y == 0) begin
      e.q  = '1;
      e.r  = x;
      e.dz = 1'b1;
    end else if (sgn && SIGNED_EN) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        e.q  = x;
        e.r  = '0;
        e.ov = 1'b1;
      end else begin
        e.q = sx / sy;
        e.r = sx % sy;
      end
    end else begin
      e.q = x / y;
      e.r = x % y;
    end
    return e;
  endfunction

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks timing, results and hold behaviour after every edge
  initial begin
    exp_t e;
    bit   exp_done;
    bit   exp_busy;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL done_timeout: got no done expected done at cycle %0d", exp_q[0].done_cyc);
        void'(exp_q.pop_front());
      end
      exp_done = (exp_q.size() > 0) && (cyc == exp_q[0].done_cyc);
      exp_busy = (exp_q.size() > 0) && !exp_done;
      check_output("done", {31'd0, done}, {31'd0, exp_done});
      check_output("busy", {31'd0, busy}, {31'd0, exp_busy});
      if (exp_done) begin
        e = exp_q.pop_front();
        check_output("quotient", quotient, e.q);
        check_output("remainder", remainder, e.r);
        check_output("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        check_output("overflow", {31'd0, overflow}, {31'd0, e.ov});
        hold_q = e.q;
        hold_r = e.r;
        hold_dz = e.dz;
        hold_ov = e.ov;
        last_done_cyc = cyc;
      end else begin
        check_output("hold_quotient", quotient, hold_q);
        check_output("hold_remainder", remainder, hold_r);
        check_output("hold_div_zero", {31'd0, div_zero}, {31'd0, hold_dz});
        check_output("hold_overflow", {31'd0, overflow}, {31'd0, hold_ov});
      end
    end
  end

  // Wait until the divider is idle per the model, then issue one operation
  task automatic apply_stimulus(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
    exp_t e;
    int guard;
    guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || cyc == last_done_cyc) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_wait: got busy scoreboard expected empty within 300 cycles");
      exp_q.delete();
    end
    start = 1'b1;
    dividend = x;
    divisor = y;
    is_signed = sgn;
    e = model(x, y, sgn);
    e.done_cyc = cyc + 1 + ((y == 0) ? 1 : W + 2);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    is_signed = 1'($urandom_range(0, 1));
  endtask

  // Start held high with fresh operands through RUN, FIX and the done cycle
  task automatic hammer_start();
    int guard;
    bit seen;
    apply_stimulus(32'd1000, 32'd13, 1'b0);
    guard = 0;
    seen = 1'b0;
    while (!seen && guard < 100) begin
      start = 1'b1;
      dividend = $urandom;
      divisor = $urandom;
      is_signed = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
      if (done) seen = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reset in the middle of RUN drops the op and clears results
  task automatic reset_mid_run();
    apply_stimulus(32'd123456, 32'd789, 1'b0);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    hold_q = '0;
    hold_r = '0;
    hold_dz = 1'b0;
    hold_ov = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(32'd20, 32'd3, 1'b0);
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    int sel;
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(32'd100, 32'd7, 1'b0);
    apply_stimulus(32'hFFFF_FFFF, 32'd1, 1'b0);
    apply_stimulus(32'd5, 32'd9, 1'b0);
    apply_stimulus(32'h1234, 32'd0, 1'b0);
    apply_stimulus(32'hFFFF_FFF9, 32'd2, 1'b1);
    apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    apply_stimulus(32'hFFFF_FFF9, 32'd0, 1'b1);
    apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    hammer_start();
    reset_mid_run();

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      x = $urandom;
      y = $urandom;
      case (sel)
        0: y = '0;
        1: y = $urandom_range(1, 15);
        2: y = $urandom;
        3: begin
          y = $urandom | 32'h8000_0000;
          x = $urandom_range(0, 1000);
        end
        4: y = 32'hFFFF_FFFF;
        default: x = 32'h8000_0000;
      endcase
      apply_stimulus(x, y, 1'($urandom_range(0, 1)));
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog in case the whole run stalls
  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog: got no finish expected finish before 1000000 ns");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
